// File: rtl/divider_cu.sv
// Control unit for a restoring shift/subtract divider: sequences load, shift,
// compare and remainder-fix steps on the datapath registers and counter.
module divider_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       R_lt_Y,
    input  logic [3:0] CNT,
    output logic       LDr,
    output logic       SLr,
    output logic       SRr,
    output logic       xLin,
    output logic       LDx,
    output logic       SLx,
    output logic       SRx,
    output logic       LDy,
    output logic       SLy,
    output logic       SRy,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       LDud,
    output logic       UDud,
    output logic       CEud,
    output logic       done,
    output logic [2:0] CS
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101,
        S6 = 3'b110,
        S7 = 3'b111
    } state_t;

    state_t state;
    state_t next_state;

    // State register; reset clears it immediately, which zeroes every output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    assign CS = state;

    // Next-state and Moore outputs (LDr in S3 also follows R_lt_Y)
    always_comb begin
        next_state = S0;
        LDr  = 1'b0;
        SLr  = 1'b0;
        SRr  = 1'b0;
        xLin = 1'b0;
        LDx  = 1'b0;
        SLx  = 1'b0;
        SRx  = 1'b0;
        LDy  = 1'b0;
        SLy  = 1'b0;
        SRy  = 1'b0;
        sel1 = 1'b0;
        sel2 = 1'b0;
        sel3 = 1'b0;
        LDud = 1'b0;
        UDud = 1'b0;
        CEud = 1'b0;
        done = 1'b0;

        case (state)
            S0: begin
                next_state = go ? S1 : S0;
            end
            S1: begin
                LDr        = 1'b1;
                LDx        = 1'b1;
                LDy        = 1'b1;
                LDud       = 1'b1;
                CEud       = 1'b1;
                next_state = S2;
            end
            S2: begin
                SLr        = 1'b1;
                SLx        = 1'b1;
                sel1       = 1'b1;
                next_state = S3;
            end
            S3: begin
                sel1       = 1'b1;
                CEud       = 1'b1;
                LDr        = ~R_lt_Y;
                next_state = R_lt_Y ? S5 : S4;
            end
            S4: begin
                SLr        = 1'b1;
                SLx        = 1'b1;
                xLin       = 1'b1;
                sel1       = 1'b1;
                next_state = (CNT == CNT_W'(0)) ? S6 : S3;
            end
            S5: begin
                SLr        = 1'b1;
                SLx        = 1'b1;
                sel1       = 1'b1;
                next_state = (CNT == CNT_W'(0)) ? S6 : S3;
            end
            S6: begin
                SRr        = 1'b1;
                sel2       = 1'b1;
                sel3       = 1'b1;
                next_state = S7;
            end
            S7: begin
                sel2       = 1'b1;
                sel3       = 1'b1;
                done       = 1'b1;
                next_state = S0;
            end
            default: begin
                next_state = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_cu.sv
// Scoreboard bench for divider_cu: stimulus pushes expected state/outputs from a
// table-driven model, a negedge monitor pops and compares against the DUT.
module tb_divider_cu;

    logic       clk;
    logic       rst;
    logic       go;
    logic       R_lt_Y;
    logic [3:0] CNT;
    logic       LDr, SLr, SRr, xLin, LDx, SLx, SRx, LDy, SLy, SRy;
    logic       sel1, sel2, sel3, LDud, UDud, CEud, done;
    logic [2:0] CS;

    divider_cu dut (
        .clk(clk), .rst(rst), .go(go), .R_lt_Y(R_lt_Y), .CNT(CNT),
        .LDr(LDr), .SLr(SLr), .SRr(SRr), .xLin(xLin),
        .LDx(LDx), .SLx(SLx), .SRx(SRx),
        .LDy(LDy), .SLy(SLy), .SRy(SRy),
        .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .LDud(LDud), .UDud(UDud), .CEud(CEud),
        .done(done), .CS(CS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] outv;
    assign outv = {LDr, SLr, SRr, xLin, LDx, SLx, SRx, LDy, SLy, SRy,
                   sel1, sel2, sel3, LDud, UDud, CEud, done};

    typedef struct packed {
        logic [2:0]  cs;
        logic [16:0] outs;
        logic [1:0]  mark;   // 1: open run window, 2: close window and check counts
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   st    = 0;

    // Output vector {LDr..done} each state is required to drive
    function automatic logic [16:0] exp_out(input int s, input logic rlt);
        case (s)
            1: return 17'b100_0100_100_000_101_0;
            2: return 17'b010_0010_000_100_000_0;
            3: return {~rlt, 16'b00_0000_000_100_001_0};
            4: return 17'b010_1010_000_100_000_0;
            5: return 17'b010_0010_000_100_000_0;
            6: return 17'b001_0000_000_011_000_0;
            7: return 17'b000_0000_000_011_000_1;
            default: return 17'd0;
        endcase
    endfunction

    function automatic int nxt(input int s, input logic g, input logic rlt, input logic [3:0] c);
        case (s)
            0: return g ? 1 : 0;
            1: return 2;
            2: return 3;
            3: return rlt ? 5 : 4;
            4, 5: return (c == 4'd0) ? 6 : 3;
            6: return 7;
            default: return 0;
        endcase
    endfunction

    // One clock of stimulus: called 1 time unit after a rising edge
    task automatic step(input logic g, input logic r, input logic [3:0] c, input logic [1:0] m);
        exp_t e;
        go = g; R_lt_Y = r; CNT = c;
        e.cs = 3'(st); e.outs = exp_out(st, r); e.mark = m;
        sbq.push_back(e);
        @(posedge clk);
        st = nxt(st, g, r, c);
        #1;
    endtask

    // Asynchronous reset between edges; monitor sees it before the next edge
    task automatic arst();
        exp_t e;
        rst = 1'b0;
        go = 1'($urandom_range(0, 1));
        e.cs = 3'd0; e.outs = 17'd0; e.mark = 2'd0;
        sbq.push_back(e);
        @(posedge clk);
        st = 0;
        #1;
        rst = 1'b1;
    endtask

    logic win = 1'b0;
    int   n_s3 = 0;
    int   n_done = 0;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            if (CS !== e.cs) begin
                bad++;
                $display("FAIL cs: got %b expected %b at %0t", CS, e.cs, $time);
            end
            total++;
            if (outv !== e.outs) begin
                bad++;
                $display("FAIL outputs(cs=%b): got %b expected %b at %0t", e.cs, outv, e.outs, $time);
            end
            if (e.mark == 2'd1) begin
                win = 1'b1; n_s3 = 0; n_done = 0;
            end
            if (win) begin
                if (CS == 3'd3) n_s3++;
                if (done) n_done++;
            end
            if (e.mark == 2'd2) begin
                win = 1'b0;
                total++;
                if (n_s3 != 4) begin
                    bad++;
                    $display("FAIL run_s3_visits: got %0d expected 4", n_s3);
                end
                total++;
                if (n_done != 1) begin
                    bad++;
                    $display("FAIL run_done_cycles: got %0d expected 1", n_done);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; go = 1'b0; R_lt_Y = 1'b0; CNT = 4'd0;
        begin
            exp_t e;
            e.cs = 3'd0; e.outs = 17'd0; e.mark = 2'd0;
            @(posedge clk); #1;
            sbq.push_back(e);
            @(posedge clk); #1;
            sbq.push_back(e);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        st = 0;

        // Directed walk through every state and branch
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b1, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd1, 2'd0);
        step(1'b0, 1'b1, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        arst();

        // High CNT bit alone must still loop back
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b1, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd8, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);

        // Full four-iteration division
        step(1'b1, 1'b0, 4'd0, 2'd1);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'd0);
            step(1'b0, 1'($urandom_range(0, 1)), 4'(3 - k), 2'd0);
        end
        step(1'b0, 1'b0, 4'd0, 2'd0);
        step(1'b1, 1'b0, 4'd0, 2'd0);
        step(1'b0, 1'b0, 4'd0, 2'd2);

        // Randomized traffic with occasional mid-operation resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                arst();
            end else begin
                step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)), 2'd0);
            end
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
